// File: rtl/serial_rx_cfg.sv
// serial_rx_cfg: UART receiver with parity, framing and break detection.
// Define SERIAL_RX_MAJORITY_EN to vote each bit 2-of-3 around its centre.
module serial_rx_cfg #(
   parameter int CLK_FREQ  = 48_000_000,
   parameter int BAUD_RATE = 115_200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   output logic                 o_wr,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_perr,
   output logic                 o_ferr,
   output logic                 o_break
);
   localparam int BAUD_CLKS = CLK_FREQ / BAUD_RATE;
   localparam int CW        = $clog2(BAUD_CLKS) + 1;
   localparam int DW        = $clog2(DATA_BITS + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_BRK   = 3'd5;

   generate
      if (BAUD_CLKS < 4) begin : g_bad_baud
         $error("serial_rx_cfg: CLK_FREQ/BAUD_RATE must be at least 4");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
         $error("serial_rx_cfg: DATA_BITS must be 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_par
         $error("serial_rx_cfg: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
         $error("serial_rx_cfg: STOP_BITS must be 1 or 2");
      end
   endgenerate

   logic [1:0]           sync_q, sync_d;
   logic [1:0]           svld_q, svld_d;
   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DW-1:0]        dcnt_q, dcnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 perr_pend_q, perr_pend_d;
   logic                 ferr_pend_q, ferr_pend_d;
   logic                 all_low_q, all_low_d;
   logic                 armed_q, armed_d;
   logic                 wr_q, wr_d;
   logic                 brk_q, brk_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;

   logic rx_s, busy, tick, act, bitv, all_low_f, ferr_f;

   assign rx_s = sync_q[1];
   assign busy = (state_q == S_START) || (state_q == S_DATA) ||
                 (state_q == S_PAR)   || (state_q == S_STOP);
   // tick marks the bit centre; the counter reloads there regardless of voting mode
   assign tick = busy && (cnt_q == CW'(1));

`ifdef SERIAL_RX_MAJORITY_EN
   logic [1:0] hist_q, hist_d;
   logic       tick_q, tick_d;

   assign hist_d = {hist_q[0], rx_s};
   assign tick_d = tick;
   // Decide one cycle after the centre: rx_s is centre+1, hist holds centre and centre-1
   assign act    = tick_q;
   assign bitv   = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hist_q <= 2'b11;
         tick_q <= 1'b0;
      end else begin
         hist_q <= hist_d;
         tick_q <= tick_d;
      end
   end
`else
   assign act  = tick;
   assign bitv = rx_s;
`endif

   assign sync_d = {sync_q[0], i_rx};
   assign svld_d = {svld_q[0], 1'b1};

   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      dcnt_d      = dcnt_q;
      shreg_d     = shreg_q;
      par_d       = par_q;
      perr_pend_d = perr_pend_q;
      ferr_pend_d = ferr_pend_q;
      all_low_d   = all_low_q;
      armed_d     = armed_q;
      wr_d        = 1'b0;
      brk_d       = 1'b0;
      data_d      = data_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      all_low_f   = all_low_q & ~bitv;
      ferr_f      = ferr_pend_q | ~bitv;

      // Only a high seen through a primed synchroniser re-enables start detection
      if (svld_q[1] && rx_s) armed_d = 1'b1;

      if (busy) cnt_d = (cnt_q == CW'(1)) ? CW'(BAUD_CLKS) : cnt_q - 1'b1;

      case (state_q)
         S_IDLE: begin
            if (!rx_s && armed_q) begin
               state_d = S_START;
               cnt_d   = CW'(BAUD_CLKS / 2);
            end
         end
         S_START: begin
            if (act) begin
               if (bitv) begin
                  state_d = S_IDLE;
               end else begin
                  state_d     = S_DATA;
                  dcnt_d      = '0;
                  par_d       = 1'b0;
                  perr_pend_d = 1'b0;
                  ferr_pend_d = 1'b0;
                  all_low_d   = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (act) begin
               shreg_d   = {bitv, shreg_q[DATA_BITS-1:1]};
               par_d     = par_q ^ bitv;
               all_low_d = all_low_f;
               if (dcnt_q == DW'(DATA_BITS - 1)) begin
                  dcnt_d  = '0;
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  dcnt_d = dcnt_q + 1'b1;
               end
            end
         end
         S_PAR: begin
            if (act) begin
               all_low_d   = all_low_f;
               perr_pend_d = (PARITY == 1) ? ~(par_q ^ bitv) : (par_q ^ bitv);
               state_d     = S_STOP;
            end
         end
         S_STOP: begin
            if (act) begin
               if (dcnt_q == DW'(STOP_BITS - 1)) begin
                  dcnt_d = '0;
                  if (!bitv) armed_d = 1'b0;
                  if (all_low_f) begin
                     brk_d   = 1'b1;
                     state_d = S_BRK;
                  end else begin
                     wr_d    = 1'b1;
                     data_d  = shreg_q;
                     perr_d  = perr_pend_q;
                     ferr_d  = ferr_f;
                     state_d = S_IDLE;
                  end
               end else begin
                  dcnt_d      = dcnt_q + 1'b1;
                  ferr_pend_d = ferr_f;
                  all_low_d   = all_low_f;
               end
            end
         end
         S_BRK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q      <= 2'b11;
         svld_q      <= 2'b00;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dcnt_q      <= '0;
         shreg_q     <= '0;
         par_q       <= 1'b0;
         perr_pend_q <= 1'b0;
         ferr_pend_q <= 1'b0;
         all_low_q   <= 1'b0;
         armed_q     <= 1'b0;
         wr_q        <= 1'b0;
         brk_q       <= 1'b0;
         data_q      <= '0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         svld_q      <= svld_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dcnt_q      <= dcnt_d;
         shreg_q     <= shreg_d;
         par_q       <= par_d;
         perr_pend_q <= perr_pend_d;
         ferr_pend_q <= ferr_pend_d;
         all_low_q   <= all_low_d;
         armed_q     <= armed_d;
         wr_q        <= wr_d;
         brk_q       <= brk_d;
         data_q      <= data_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
      end
   end

   assign o_wr    = wr_q;
   assign o_break = brk_q;
   assign o_data  = data_q;
   assign o_perr  = perr_q;
   assign o_ferr  = ferr_q;
endmodule

// File: tb/tb_serial_rx_cfg.sv
// Bench for serial_rx_cfg: an 8N1 and an 8E1 receiver driven by directed and random frames.
module tb_serial_rx_cfg;
   localparam int CF = 500_000;
   localparam int BR = 115_200;
   localparam int BC = CF / BR;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_n = 1'b1;
   logic rx_e = 1'b1;
   logic wr_n, perr_n, ferr_n, brk_n;
   logic wr_e, perr_e, ferr_e, brk_e;
   logic [7:0] data_n, data_e;

   int errors = 0;
   int checks = 0;
   int wr_cnt_n = 0, brk_cnt_n = 0, wr_cnt_e = 0, brk_cnt_e = 0;

   // model's view of the held outputs of each receiver
   logic [7:0] m_data [2];
   logic       m_perr [2];
   logic       m_ferr [2];

   always #5 clk = ~clk;

   serial_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_n), .o_wr(wr_n), .o_data(data_n),
      .o_perr(perr_n), .o_ferr(ferr_n), .o_break(brk_n));

   serial_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_e), .o_wr(wr_e), .o_data(data_e),
      .o_perr(perr_e), .o_ferr(ferr_e), .o_break(brk_e));

   // counting high cycles also proves each pulse lasts exactly one cycle
   always @(negedge clk) begin
      if (wr_n === 1'b1) wr_cnt_n++;
      if (brk_n === 1'b1) brk_cnt_n++;
      if (wr_e === 1'b1) wr_cnt_e++;
      if (brk_e === 1'b1) brk_cnt_e++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit e, input logic v);
      if (e) rx_e = v;
      else   rx_n = v;
   endtask

   task automatic send_frame(input bit e, input logic [7:0] d, input logic pbit, input logic sbit);
      logic [11:0] bits;
      int n;
      bits = '0;
      n = 1;
      for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
      if (e) begin bits[n] = pbit; n++; end
      bits[n] = sbit;
      n++;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         drive(e, bits[i]);
         repeat (BC) @(posedge clk);
         #1;
      end
      drive(e, 1'b1);
      repeat (4 * BC) @(posedge clk);
      #1;
   endtask

   // Reference: a frame is a break when every bit after the start is low;
   // otherwise it delivers the data, parity by popcount, framing by the stop bit.
   task automatic run_frame(input string tag, input bit e, input logic [7:0] d,
                            input logic pbit, input logic sbit);
      int w0, b0, ones;
      bit brk;
      w0 = e ? wr_cnt_e : wr_cnt_n;
      b0 = e ? brk_cnt_e : brk_cnt_n;
      brk = (d == 8'h00) && (!e || !pbit) && !sbit;
      ones = $countones(d) + (e ? int'(pbit) : 0);
      if (!brk) begin
         m_data[e] = d;
         m_perr[e] = e ? (ones % 2 == 1) : 1'b0;
         m_ferr[e] = !sbit;
      end
      send_frame(e, d, pbit, sbit);
      check({tag, ".wr"},   (e ? wr_cnt_e : wr_cnt_n) - w0, brk ? 0 : 1);
      check({tag, ".brk"},  (e ? brk_cnt_e : brk_cnt_n) - b0, brk ? 1 : 0);
      check({tag, ".data"}, e ? data_e : data_n, m_data[e]);
      check({tag, ".perr"}, e ? perr_e : perr_n, m_perr[e]);
      check({tag, ".ferr"}, e ? ferr_e : ferr_n, m_ferr[e]);
   endtask

   initial begin
      int w0, b0;
      logic [7:0] rd;
      logic rp, rs;
      for (int i = 0; i < 2; i++) begin m_data[i] = '0; m_perr[i] = 1'b0; m_ferr[i] = 1'b0; end

      repeat (3) @(posedge clk);
      #2;
      check("rst.wr", wr_n, 0);
      check("rst.brk", brk_n, 0);
      check("rst.data", data_n, 0);
      check("rst.perr_e", perr_e, 0);
      check("rst.ferr", ferr_n, 0);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);

      run_frame("k8n1", 1'b0, 8'h4B, 1'b0, 1'b1);
      run_frame("par_bad", 1'b1, 8'h4B, 1'b1, 1'b1);
      run_frame("par_ok", 1'b1, 8'h4B, 1'b0, 1'b1);
      run_frame("ferr", 1'b0, 8'h55, 1'b0, 1'b0);
      run_frame("ferr_clr", 1'b0, 8'h0F, 1'b0, 1'b1);

      // one-cycle glitch in idle
      w0 = wr_cnt_n; b0 = brk_cnt_n;
      @(posedge clk); #1; rx_n = 1'b0;
      @(posedge clk); #1; rx_n = 1'b1;
      repeat (4 * BC) @(posedge clk);
      #1;
      check("glitch.wr", wr_cnt_n - w0, 0);
      check("glitch.brk", brk_cnt_n - b0, 0);
      run_frame("post_glitch", 1'b0, 8'h4B, 1'b0, 1'b1);

      // 12 bit-time break
      w0 = wr_cnt_n; b0 = brk_cnt_n;
      @(posedge clk); #1; rx_n = 1'b0;
      repeat (12 * BC) @(posedge clk);
      #1;
      check("brk.wr_inside", wr_cnt_n - w0, 0);
      rx_n = 1'b1;
      repeat (4 * BC) @(posedge clk);
      #1;
      check("brk.pulse", brk_cnt_n - b0, 1);
      check("brk.wr", wr_cnt_n - w0, 0);
      check("brk.data_held", data_n, m_data[0]);
      run_frame("post_brk", 1'b0, 8'h41, 1'b0, 1'b1);

      // reset after bit 3 of 0xA5
      w0 = wr_cnt_n;
      @(posedge clk); #1; rx_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         repeat (BC) @(posedge clk);
         #1;
         rx_n = 1'(8'hA5 >> i);
      end
      repeat (BC) @(posedge clk);
      #1;
      rx_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("midrst.wr", wr_n, 0);
      check("midrst.data", data_n, 0);
      check("midrst.perr", perr_n, 0);
      check("midrst.ferr", ferr_n, 0);
      check("midrst.brk", brk_n, 0);
      check("midrst.data_e", data_e, 0);
      for (int i = 0; i < 2; i++) begin m_data[i] = '0; m_perr[i] = 1'b0; m_ferr[i] = 1'b0; end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (12 * BC) @(posedge clk);
      #1;
      check("midrst.no_wr", wr_cnt_n - w0, 0);
      run_frame("post_rst", 1'b0, 8'h3C, 1'b0, 1'b1);

      // random frames against the model
      for (int i = 0; i < 12; i++) begin
         rd = 8'($urandom_range(0, 255));
         rp = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 3) != 0);
         run_frame($sformatf("rnd%0d", i), 1'(i % 2), rd, rp, rs);
      end
      run_frame("brk_e", 1'b1, 8'h00, 1'b0, 1'b0);
      run_frame("zero_ok_e", 1'b1, 8'h00, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
